// File: rtl/image_stream_tx.sv
// Frame source for the vsync/href/gray pixel stream: reads a stored frame from a
// 1-cycle-latency memory and emits it row by row with horizontal and vertical blanking.
module image_stream_tx #(
    parameter int IMG_H_DISP   = 512,
    parameter int IMG_V_DISP   = 512,
    parameter int H_BLANK_PRE  = 5,
    parameter int H_BLANK_POST = 5,
    parameter int V_BLANK      = 10,
    parameter int ADDR_W       = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              per_img_vsync,
    output logic              per_img_href,
    output logic [7:0]        per_img_gray,
    output logic              busy,
    output logic              frame_done
);
    localparam int MAX_HP  = (H_BLANK_PRE > IMG_H_DISP) ? H_BLANK_PRE : IMG_H_DISP;
    localparam int MAX_PV  = (H_BLANK_POST > V_BLANK) ? H_BLANK_POST : V_BLANK;
    localparam int CNT_MAX = (MAX_HP > MAX_PV) ? MAX_HP : MAX_PV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = $clog2(IMG_V_DISP + 1);

    typedef enum logic [2:0] {S_IDLE, S_H_PRE, S_H_ACT, S_H_POST, S_V_BLK} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [ADDR_W-1:0]  addr_cnt_reg, addr_cnt_next, addr_base;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic               mem_rd_reg, mem_rd_next;
    logic               vsync_reg, vsync_next;
    logic               href_reg, href_next;
    logic [7:0]         gray_reg, gray_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               frame_start;

    // State, counters and all outputs are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            row_reg      <= '0;
            addr_cnt_reg <= '0;
            mem_addr_reg <= '0;
            mem_rd_reg   <= 1'b0;
            vsync_reg    <= 1'b0;
            href_reg     <= 1'b0;
            gray_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            row_reg      <= row_next;
            addr_cnt_reg <= addr_cnt_next;
            mem_addr_reg <= mem_addr_next;
            mem_rd_reg   <= mem_rd_next;
            vsync_reg    <= vsync_next;
            href_reg     <= href_next;
            gray_reg     <= gray_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        row_next   = row_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (start) state_next = S_H_PRE;
            end
            S_H_PRE: begin
                if (int'(cnt_reg) == H_BLANK_PRE - 1) begin
                    state_next = S_H_ACT;
                    cnt_next   = '0;
                end
            end
            S_H_ACT: begin
                if (int'(cnt_reg) == IMG_H_DISP - 1) begin
                    state_next = S_H_POST;
                    cnt_next   = '0;
                end
            end
            S_H_POST: begin
                if (int'(cnt_reg) == H_BLANK_POST - 1) begin
                    cnt_next = '0;
                    if (int'(row_reg) == IMG_V_DISP - 1) begin
                        state_next = S_V_BLK;
                        row_next   = '0;
                    end else begin
                        state_next = S_H_PRE;
                        row_next   = row_reg + 1'b1;
                    end
                end
            end
            S_V_BLK: begin
                if (int'(cnt_reg) == V_BLANK - 1) begin
                    cnt_next   = '0;
                    state_next = continuous ? S_H_PRE : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                row_next   = '0;
            end
        endcase
    end

    // Reads run two cycles ahead of href: one for memory latency, one for the gray register
    always_comb begin
        frame_start = (state_reg == S_IDLE || state_reg == S_V_BLK) && (state_next == S_H_PRE);
        addr_base   = frame_start ? '0 : addr_cnt_reg;
        mem_rd_next = 1'b0;
        case (state_next)
            S_H_PRE: mem_rd_next = int'(cnt_next) >= H_BLANK_PRE - 2;
            S_H_ACT: mem_rd_next = int'(cnt_next) < IMG_H_DISP - 2;
            default: mem_rd_next = 1'b0;
        endcase
        mem_addr_next = mem_rd_next ? addr_base : mem_addr_reg;
        addr_cnt_next = mem_rd_next ? addr_base + 1'b1 : addr_base;
        vsync_next    = (state_next == S_H_PRE) || (state_next == S_H_ACT) || (state_next == S_H_POST);
        href_next     = (state_next == S_H_ACT);
        gray_next     = href_next ? mem_data : '0;
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_reg == S_H_POST) && (state_next == S_V_BLK);
    end

    assign mem_rd        = mem_rd_reg;
    assign mem_addr      = mem_addr_reg;
    assign per_img_vsync = vsync_reg;
    assign per_img_href  = href_reg;
    assign per_img_gray  = gray_reg;
    assign busy          = busy_reg;
    assign frame_done    = done_reg;
endmodule
